// File: rtl/fmdll_pkg.sv
// Shared definitions for the FMDLL coarse phase search and its downstream tap decoder.
package fmdll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP,
        ST_DONE
    } fmdll_cstate_t;

    localparam logic [2:0] Q_RESET   = 3'd4;
    localparam logic [3:0] MAX_STEPS = 4'd6;

    // A window of win_len votes spans -win_len..+win_len, which always fits in this width.
    function automatic int vote_width(input int win_len);
        return $clog2(win_len) + 2;
    endfunction

endpackage

// File: rtl/fmdll_vote_acc.sv
// Phase-detector vote window: counts WIN_LEN run cycles and sums +1/-1 votes.
// vote holds the total of the most recently completed window; done flags its last cycle.
module fmdll_vote_acc
    import fmdll_pkg::*;
#(
    parameter  int WIN_LEN = 8,
    localparam int VW      = vote_width(WIN_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 run,
    input  logic                 pd_up,
    input  logic                 pd_dn,
    output logic                 done,
    output logic signed [VW-1:0] vote
);

    localparam int CW = $clog2(WIN_LEN);

    logic        [CW-1:0] cnt;
    logic signed [VW-1:0] acc;
    logic signed [VW-1:0] delta;

    always_comb begin
        delta = '0;
        if (pd_up && !pd_dn) begin
            delta = VW'(1);
        end else if (pd_dn && !pd_up) begin
            delta = '1;
        end
    end

    assign done = run && !clr && (cnt == CW'(WIN_LEN - 1));

    // Windows restart back to back, so the final sum is latched and acc reloads from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            acc  <= '0;
            vote <= '0;
        end else if (clr) begin
            cnt  <= '0;
            acc  <= '0;
            vote <= '0;
        end else if (run) begin
            if (done) begin
                cnt  <= '0;
                acc  <= '0;
                vote <= acc + delta;
            end else begin
                cnt <= cnt + 1'b1;
                acc <= acc + delta;
            end
        end
    end

endmodule

// File: rtl/fmdll_coarse_ctrl.sv
// Coarse tap-code search for the FMDLL: settle, vote, step Q, lock after MAX_STEPS steps.
// Optional DONE-state relock monitoring is built when FMDLL_RELOCK_EN is defined.
module fmdll_coarse_ctrl
    import fmdll_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int WIN_LEN    = 8,
    parameter int RELOCK_TH  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pd_up,
    input  logic       pd_dn,
    output logic [2:0] Q,
    output logic [3:0] count,
    output logic       lock
);

    localparam int VW = vote_width(WIN_LEN);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || WIN_LEN < 2 || WIN_LEN > 64 || RELOCK_TH < 1) begin : g_param_check
        $error("fmdll_coarse_ctrl: parameter out of range");
    end

    fmdll_cstate_t        state, state_nx;
    logic [2:0]           q_nx;
    logic [3:0]           count_nx;
    logic                 lock_nx;
    logic [3:0]           settle_cnt;
    logic                 settle_last;
    logic                 acc_clr;
    logic                 acc_run;
    logic                 win_done;
    logic signed [VW-1:0] vote;

    fmdll_vote_acc #(
        .WIN_LEN (WIN_LEN)
    ) u_vote_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .run   (acc_run),
        .pd_up (pd_up),
        .pd_dn (pd_dn),
        .done  (win_done),
        .vote  (vote)
    );

    assign settle_last = (settle_cnt == 4'(SETTLE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE && !settle_last) begin
            settle_cnt <= settle_cnt + 4'd1;
        end else begin
            settle_cnt <= '0;
        end
    end

`ifdef FMDLL_RELOCK_EN
    logic          win_seen;
    logic          strike;
    logic          strong;
    logic          relock;
    logic [VW-1:0] vote_mag;

    assign vote_mag = vote[VW-1] ? VW'(-vote) : VW'(vote);
    assign strong   = int'(vote_mag) >= RELOCK_TH;
    assign relock   = (state == ST_DONE) && win_seen && strong && strike;

    // win_seen marks the cycle in which vote holds a freshly finished DONE window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_seen <= 1'b0;
            strike   <= 1'b0;
        end else begin
            win_seen <= (state == ST_DONE) && win_done;
            if (state != ST_DONE) begin
                strike <= 1'b0;
            end else if (win_seen) begin
                strike <= strong;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            Q     <= Q_RESET;
            count <= '0;
            lock  <= 1'b0;
        end else begin
            state <= state_nx;
            Q     <= q_nx;
            count <= count_nx;
            lock  <= lock_nx;
        end
    end

    always_comb begin
        state_nx = state;
        q_nx     = Q;
        count_nx = count;
        lock_nx  = lock;
        acc_clr  = 1'b1;
        acc_run  = 1'b0;
        if (!en) begin
            state_nx = ST_IDLE;
            q_nx     = Q_RESET;
            count_nx = '0;
            lock_nx  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_SETTLE;
                    q_nx     = Q_RESET;
                    count_nx = '0;
                    lock_nx  = 1'b0;
                end
                ST_SETTLE: begin
                    if (settle_last) begin
                        state_nx = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    acc_clr = 1'b0;
                    acc_run = 1'b1;
                    if (win_done) begin
                        state_nx = ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (vote > 0 && Q != 3'd7) begin
                        q_nx = Q + 3'd1;
                    end else if (vote < 0 && Q != 3'd0) begin
                        q_nx = Q - 3'd1;
                    end
                    count_nx = count + 4'd1;
                    if (count_nx == MAX_STEPS) begin
                        state_nx = ST_DONE;
                        lock_nx  = 1'b1;
                    end else begin
                        state_nx = ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    lock_nx = 1'b1;
`ifdef FMDLL_RELOCK_EN
                    acc_clr = 1'b0;
                    acc_run = 1'b1;
                    if (relock) begin
                        state_nx = ST_SETTLE;
                        count_nx = '0;
                        lock_nx  = 1'b0;
                    end
`endif
                end
                default: begin
                    state_nx = ST_IDLE;
                    q_nx     = Q_RESET;
                    count_nx = '0;
                    lock_nx  = 1'b0;
                end
            endcase
        end
    end

endmodule
